// File: rtl/sdram_fill_dma.sv
// Rectangular SDRAM fill engine: CPU-programmed register window, single-word
// non-burst writes of a constant pattern, row by row, on the arbiter's bus3 port.
module sdram_fill_dma (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpud_request,
    input  logic [4:0]  cpud_addr,
    input  logic        cpud_write,
    input  logic [3:0]  cpud_byte_enable,
    input  logic [31:0] cpud_wdata,
    output logic [31:0] cpud_rdata,
    output logic        cpud_ack,
    output logic        sdram_request,
    output logic [25:0] sdram_addr,
    output logic        sdram_write,
    output logic        sdram_burst,
    output logic [3:0]  sdram_byte_enable,
    output logic [31:0] sdram_wdata,
    input  logic        sdram_ack,
    output logic        done_irq
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t      state, state_nx;

    // Programmed registers (CPU visible)
    logic [25:0] dest_r;
    logic [11:0] width_r;
    logic [11:0] height_r;
    logic [15:0] stride_r;
    logic [31:0] fill_r;
    logic [3:0]  byteen_r;

    // Working copies latched at start, so CPU writes mid-job only affect the next job
    logic [11:0] w_width;
    logic [11:0] w_height;
    logic [15:0] w_stride;
    logic [31:0] w_fill;
    logic [3:0]  w_byteen;
    logic [11:0] col;
    logic [11:0] row;
    logic [25:0] addr;
    logic [25:0] row_base;
    logic [25:0] next_row;
    logic        done_f;
    logic        aborted_f;

    logic [2:0]  reg_sel;
    logic        wr_en;
    logic        ctrl_wr;
    logic        start_cmd;
    logic        abort_cmd;
    logic        last_col;
    logic        last_word;
    logic        busy;
    logic [31:0] rd_val;

    // Byte enables and the low address bits carry no meaning for this window
    logic        unused_cpud;
    assign unused_cpud = ^{cpud_byte_enable, cpud_addr[1:0]};

    assign reg_sel   = cpud_addr[4:2];
    assign wr_en     = cpud_request & cpud_write;
    assign ctrl_wr   = wr_en & (reg_sel == 3'd6);
    // Abort takes priority when both bits are written together
    assign start_cmd = ctrl_wr & cpud_wdata[0] & ~cpud_wdata[1];
    assign abort_cmd = ctrl_wr & cpud_wdata[1];

    assign last_col  = (col == w_width - 12'd1);
    assign last_word = last_col & (row == w_height - 12'd1);
    assign next_row  = row_base + {10'd0, w_stride};
    assign busy      = (state != IDLE);

    // Register file writes; alignment bits are dropped on the way in
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dest_r   <= '0;
            width_r  <= '0;
            height_r <= '0;
            stride_r <= '0;
            fill_r   <= '0;
            byteen_r <= 4'hF;
        end else if (wr_en) begin
            case (reg_sel)
                3'd0: dest_r   <= {cpud_wdata[25:2], 2'b00};
                3'd1: width_r  <= cpud_wdata[11:0];
                3'd2: height_r <= cpud_wdata[11:0];
                3'd3: stride_r <= {cpud_wdata[15:2], 2'b00};
                3'd4: fill_r   <= cpud_wdata;
                3'd5: byteen_r <= cpud_wdata[3:0];
                default: ;
            endcase
        end
    end

    // Readback mux; unmapped offsets return zero
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            3'd0: rd_val = {6'd0, dest_r};
            3'd1: rd_val = {20'd0, width_r};
            3'd2: rd_val = {20'd0, height_r};
            3'd3: rd_val = {16'd0, stride_r};
            3'd4: rd_val = fill_r;
            3'd5: rd_val = {28'd0, byteen_r};
            3'd6: rd_val = {29'd0, aborted_f, done_f, busy};
            default: rd_val = '0;
        endcase
    end

    // Registered CPU response: ack one cycle after request, data only for reads
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cpud_ack   <= 1'b0;
            cpud_rdata <= '0;
        end else begin
            cpud_ack   <= cpud_request;
            cpud_rdata <= (cpud_request & ~cpud_write) ? rd_val : 32'd0;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_cmd)
                    state_nx = (width_r != 12'd0 && height_r != 12'd0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (abort_cmd)
                    state_nx = IDLE;
                else if (sdram_ack && last_word)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Job datapath: latch job on start, walk col/row on each accepted word, status flags
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            w_width   <= '0;
            w_height  <= '0;
            w_stride  <= '0;
            w_fill    <= '0;
            w_byteen  <= '0;
            col       <= '0;
            row       <= '0;
            addr      <= '0;
            row_base  <= '0;
            done_f    <= 1'b0;
            aborted_f <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        w_width   <= width_r;
                        w_height  <= height_r;
                        w_stride  <= stride_r;
                        w_fill    <= fill_r;
                        w_byteen  <= byteen_r;
                        col       <= '0;
                        row       <= '0;
                        addr      <= dest_r;
                        row_base  <= dest_r;
                        done_f    <= 1'b0;
                        aborted_f <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (abort_cmd)
                        aborted_f <= 1'b1;
                    if (sdram_ack && !last_word) begin
                        if (!last_col) begin
                            col  <= col + 12'd1;
                            addr <= addr + 26'd4;
                        end else begin
                            col      <= '0;
                            row      <= row + 12'd1;
                            row_base <= next_row;
                            addr     <= next_row;
                        end
                    end
                end
                DONE:    done_f <= 1'b1;
                default: ;
            endcase
        end
    end

    // Bus outputs are zero whenever no word is being offered
    assign sdram_request     = (state == ISSUE);
    assign sdram_addr        = sdram_request ? addr     : 26'd0;
    assign sdram_wdata       = sdram_request ? w_fill   : 32'd0;
    assign sdram_byte_enable = sdram_request ? w_byteen : 4'd0;
    assign sdram_write       = 1'b1;
    assign sdram_burst       = 1'b0;
    assign done_irq          = (state == DONE);

endmodule

// File: doc/sdram_fill_dma.md
# sdram_fill_dma

Rectangular fill engine that writes a constant 32-bit pattern into SDRAM. It is the write-direction initiator on the arbiter's spare bus3 port, complementing the read-only VGA master on bus1. The CPU programs it through a small register window selected by the address decoder on the cpud bus. It then issues single-word, non-burst write requests row by row until the rectangle is filled.

## Interface
- No parameters.
- `clock`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `cpud_request`  in  1  register access strobe from the address decoder, one cycle.
- `cpud_addr`  in  5  byte address within the window; bits [1:0] are ignored.
- `cpud_write`  in  1  1 = write, 0 = read.
- `cpud_byte_enable`  in  4  ignored; registers are written whole.
- `cpud_wdata`  in  32  register write data.
- `cpud_rdata`  out  32  register read data, valid with `cpud_ack`.
- `cpud_ack`  out  1  access complete.
- `sdram_request`  out  1  to arbiter bus3_request.
- `sdram_addr`  out  26  byte address; always word-aligned.
- `sdram_write`  out  1  tied to 1.
- `sdram_burst`  out  1  tied to 0.
- `sdram_byte_enable`  out  4  per-byte write enable.
- `sdram_wdata`  out  32  fill pattern.
- `sdram_ack`  in  1  arbiter accepted the current word.
- `done_irq`  out  1  one-cycle pulse when a job completes normally.

## Operation
- Register map (word offsets):
  - 0x00 DEST[25:0]: start byte address; bits [1:0] are forced to 0.
  - 0x04 WIDTH[11:0]: words per row.
  - 0x08 HEIGHT[11:0]: number of rows.
  - 0x0C STRIDE[15:0]: row pitch in bytes; bits [1:0] are forced to 0.
  - 0x10 FILL[31:0]: fill pattern.
  - 0x14 BYTEEN[3:0]: byte enables.
  - 0x18 CTRL/STATUS:
    - Write: bit0 = start, bit1 = abort.
    - Read: bit0 = busy, bit1 = done, bit2 = aborted.
- Unmapped offsets read as 0. Writes to unmapped offsets are ignored. Readback returns the zero-extended register value.
- On start, the engine copies DEST, WIDTH, HEIGHT, STRIDE, FILL and BYTEEN into working registers. Register writes made while busy therefore affect only the next job.
- State machine IDLE / ISSUE / DONE:
  - IDLE + start with WIDTH≠0 and HEIGHT≠0: go to ISSUE. Set col = 0, row = 0, addr = row_base = DEST. Clear done and aborted.
  - IDLE + start with WIDTH=0 or HEIGHT=0: go to DONE. No SDRAM request is issued.
  - ISSUE: drive `sdram_request`=1 with addr, FILL and BYTEEN. Hold all of them stable until `sdram_ack`. On ack:
    - col < WIDTH−1: col++ and addr += 4.
    - col = WIDTH−1 and row < HEIGHT−1: row++, col = 0, row_base += STRIDE, addr = row_base + STRIDE.
    - col = WIDTH−1 and row = HEIGHT−1: go to DONE.
  - DONE: for one cycle, pulse `done_irq` and set done. Then return to IDLE.
- Start while busy is ignored.
- Abort while in ISSUE:
  - Go to IDLE and set aborted. `done_irq` does not fire.
  - If `sdram_ack` is high in the same cycle, that word counts as written.
  - Abort while in IDLE is ignored.
- Start and abort written together: abort wins and start is ignored.
- All address arithmetic is modulo 2^26, so 0x3FFFFFC + 4 = 0x0000000.

## Timing
- Register access:
  - `cpud_ack` is registered and asserts exactly one cycle after `cpud_request`.
  - For reads, `cpud_rdata` is valid in the ack cycle and 0 otherwise.
  - Writes take effect at the edge that ends the request cycle.
- Start written in cycle T: `sdram_request` rises in cycle T+1 and busy reads 1 from T+1.
- Streaming:
  - After an ack in cycle N, the next address is presented in N+1 with request still high.
  - With ack held high continuously, one word is written per cycle.
- Completion: after the final ack in cycle N, `sdram_request`=0 in N+1. `done_irq`=1 in N+1 only. done reads 1 from N+2.
- Abort written in cycle T: `sdram_request`=0 from T+1.
- Reset values (`reset_n`=0 sampled at an edge):
  - All registers 0, except BYTEEN = 4'hF.
  - State IDLE; done and aborted 0.
  - `sdram_request`, `sdram_addr`, `sdram_wdata`, `sdram_byte_enable`, `cpud_ack`, `cpud_rdata` and `done_irq` all 0.
- Reset mid-job: the request drops in the cycle after reset is sampled. No completion is reported.

## Test plan
- Register readback: write DEST=0x1234567 → reads 0x1234564. Write STRIDE=0x1FFFF → reads 0xFFFC. Offset 0x1C reads 0. BYTEEN reads 0xF after reset.
- 4×1 fill, DEST=0x100, FILL=0xDEADBEEF, ack tied high → acks at 0x100, 0x104, 0x108, 0x10C on consecutive cycles, then one `done_irq` pulse and STATUS = 0x2.
- 3×2 fill, DEST=0x1000, STRIDE=0x280, ack 3 cycles after each request → address sequence 0x1000, 0x1004, 0x1008, 0x1280, 0x1284, 0x1288. Address, data and byte enables stay stable while waiting for each ack.
- WIDTH=0, start → no `sdram_request` at all; `done_irq` pulses once. A second start issued mid-job (WIDTH=8) is ignored and exactly 8 words are written.
- Wrap-around: DEST=0x3FFFFF8, WIDTH=4 → 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004.
- Abort after the 2nd ack of a 10-word job → request low next cycle, STATUS = 0x4, no `done_irq`. Repeat with `reset_n`=0 mid-job → all outputs 0 the next cycle.
